beam_mode_sequencer: RTL and testbench

Programs the ECS/AGA programmable beam registers of `agnus_beamcounter` from a built-in mode table and shares the custom-chip register write path with the CPU. A start request causes a fixed ordered burst of register writes, one per bus slot. A CPU register write always wins its cycle, and a deferred programmer write moves to the next free slot. The block sits between the CPU register bus and the beamcounter/scandoubler pair, so video mode changes such as PAL, NTSC or 31 kHz need no CPU copy loop.

---
 rtl/beam_mode_sequencer.sv | 167 ++++++++++++++++
 tb/tb_beam_mode_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_mode_sequencer.sv
// beam_mode_sequencer
// Programs the programmable beam registers of the beamcounter from a built-in
// mode table (PAL, NTSC, 31 kHz). It shares the custom-register write path with
// the CPU. CPU writes always own their cycle; a table write that collides with a
// CPU write on a slot moves to the next slot.
module beam_mode_sequencer #(
   parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk7_en,
   input  logic        cck,
   input  logic        start,
   input  logic [1:0]  mode_sel,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_reg_address_in,
   input  logic [15:0] cpu_data_in,
   output logic        reg_wr,
   output logic [7:0]  reg_address_out,
   output logic [15:0] data_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [3:0]       index_q, index_nxt;
   logic [3:0]       count_q, count_nxt;
   logic             last_p1, last_nxt;
   logic             err_nxt;
   logic             slot;
   logic             tbl_wr;
   logic [ADDR_W+DATA_W-1:0] tbl_entry_p0;

   // Mode table: {word address, data}. BEAMCON0 is always the final entry so
   // VARBEAMEN only turns on once every timing register holds its new value.
   function automatic logic [ADDR_W+DATA_W-1:0] table_entry(
      input logic [1:0] mode,
      input logic [3:0] idx
   );
      logic [ADDR_W+DATA_W-1:0] e;
      e = {IDLE_ADDR, 16'h0000};
      case (mode)
         2'd0: e = {8'hEE, 16'h0020};          // BEAMCON0: PAL
         2'd1: e = {8'hEE, 16'h0000};          // BEAMCON0: NTSC
         2'd2: begin
            case (idx)
               4'd0:  e = {8'hE0, 16'h0071};   // HTOTAL
               4'd1:  e = {8'hEF, 16'h0008};   // HSSTRT
               4'd2:  e = {8'hE1, 16'h001C};   // HSSTOP
               4'd3:  e = {8'hE2, 16'h0001};   // HBSTRT
               4'd4:  e = {8'hE3, 16'h0021};   // HBSTOP
               4'd5:  e = {8'hF1, 16'h0046};   // HCENTER
               4'd6:  e = {8'hE4, 16'h020C};   // VTOTAL
               4'd7:  e = {8'hF0, 16'h0000};   // VSSTRT
               4'd8:  e = {8'hE5, 16'h0003};   // VSSTOP
               4'd9:  e = {8'hE6, 16'h0000};   // VBSTRT
               4'd10: e = {8'hE7, 16'h0019};   // VBSTOP
               4'd11: e = {8'hEE, 16'h1B88};   // BEAMCON0: 31 kHz, VARBEAMEN
               default: e = {IDLE_ADDR, 16'h0000};
            endcase
         end
         default: e = {IDLE_ADDR, 16'h0000};
      endcase
      return e;
   endfunction

   assign slot         = clk7_en & ~cck;
   assign tbl_entry_p0 = table_entry(mode_q, index_q);
   assign busy         = (state != IDLE);
   assign done         = (state == FIN);

   // State register and sequence bookkeeping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         mode_q  <= 2'd0;
         index_q <= 4'd0;
         count_q <= 4'd0;
         last_p1 <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         mode_q  <= mode_nxt;
         index_q <= index_nxt;
         count_q <= count_nxt;
         last_p1 <= last_nxt;
         err     <= err_nxt;
      end
   end

   // Next-state logic; a table write only takes a slot the CPU leaves free
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      index_nxt = index_q;
      count_nxt = count_q;
      last_nxt  = 1'b0;
      err_nxt   = 1'b0;
      tbl_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (mode_sel == 2'd3) begin
                  err_nxt = 1'b1;
               end else begin
                  mode_nxt  = mode_sel;
                  index_nxt = 4'd0;
                  count_nxt = (mode_sel == 2'd2) ? 4'd12 : 4'd1;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (last_p1) begin
               // last entry is on the bus this cycle; done follows next cycle
               state_nxt = FIN;
            end else if (slot && !cpu_wr) begin
               tbl_wr = 1'b1;
               if (index_q == count_q - 4'd1) begin
                  last_nxt = 1'b1;
               end else begin
                  index_nxt = index_q + 4'd1;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered output mux: CPU first, then table, otherwise park on IDLE_ADDR
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         reg_wr          <= 1'b0;
         reg_address_out <= IDLE_ADDR;
         data_out        <= '0;
      end else if (cpu_wr) begin
         reg_wr          <= 1'b1;
         reg_address_out <= cpu_reg_address_in;
         data_out        <= cpu_data_in;
      end else if (tbl_wr) begin
         reg_wr          <= 1'b1;
         reg_address_out <= tbl_entry_p0[ADDR_W+DATA_W-1:DATA_W];
         data_out        <= tbl_entry_p0[DATA_W-1:0];
      end else begin
         reg_wr          <= 1'b0;
         reg_address_out <= IDLE_ADDR;
         data_out        <= '0;
      end
   end

endmodule

// File: tb/tb_beam_mode_sequencer.sv
// Testbench for beam_mode_sequencer: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_beam_mode_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clk7_en = 1'b1;
   logic        cck = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode_sel = 2'd0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_reg_address_in = 8'h00;
   logic [15:0] cpu_data_in = 16'h0000;
   logic        reg_wr;
   logic [7:0]  reg_address_out;
   logic [15:0] data_out;
   logic        busy;
   logic        done;
   logic        err;

   beam_mode_sequencer #(.IDLE_ADDR(8'hFF)) dut (
      .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .cck(cck),
      .start(start), .mode_sel(mode_sel), .cpu_wr(cpu_wr),
      .cpu_reg_address_in(cpu_reg_address_in), .cpu_data_in(cpu_data_in),
      .reg_wr(reg_wr), .reg_address_out(reg_address_out), .data_out(data_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;
   int phase = 0;        // phase (0..7) of the next active edge; slot at 0
   int wr_count = 0;     // reg_wr pulses observed since last clear
   int done_count = 0;
   int last_wr_cyc = -1;
   int cyc = 0;
   int gap_bad = 0;

   // reference model
   logic [23:0] pend[$];
   bit          m_busy = 0;
   int          m_after = 0;   // 1: last table write on bus, 2: done cycle
   logic        e_wr, e_done, e_err, e_busy;
   logic [7:0]  e_addr;
   logic [15:0] e_data;

   int unsigned byte_off[12] = '{'h1C0, 'h1DE, 'h1C2, 'h1C4, 'h1C6, 'h1E2,
                                 'h1C8, 'h1E0, 'h1CA, 'h1CC, 'h1CE, 'h1DC};
   logic [15:0] m2_val[12]   = '{16'h0071, 16'h0008, 16'h001C, 16'h0001,
                                 16'h0021, 16'h0046, 16'h020C, 16'h0000,
                                 16'h0003, 16'h0000, 16'h0019, 16'h1B88};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_mode(input logic [1:0] m);
      logic [11:0] beamcon0;
      beamcon0 = 12'h1DC;
      pend.delete();
      if (m == 2'd2) begin
         for (int i = 0; i < 12; i++) begin
            logic [11:0] o;
            o = 12'(byte_off[i]);
            pend.push_back({o[8:1], m2_val[i]});
         end
      end else begin
         pend.push_back({beamcon0[8:1], (m == 2'd0) ? 16'h0020 : 16'h0000});
      end
   endtask

   // advance the model by one active edge using the inputs the DUT just sampled
   task automatic model_edge(input bit slot_now);
      bit nb;
      logic [23:0] ent;
      e_wr = 0; e_addr = 8'hFF; e_data = 16'h0000; e_err = 0;
      if (!reset_n) begin
         pend.delete();
         m_busy = 0; m_after = 0;
         e_done = 0; e_busy = 0;
         return;
      end
      if (cpu_wr) begin
         e_wr = 1; e_addr = cpu_reg_address_in; e_data = cpu_data_in;
      end
      nb = m_busy;
      if (!m_busy) begin
         if (start) begin
            if (mode_sel == 2'd3) e_err = 1;
            else begin
               load_mode(mode_sel);
               nb = 1;
            end
         end
      end else if (pend.size() > 0) begin
         if (slot_now && !cpu_wr) begin
            ent = pend.pop_front();
            e_wr = 1; e_addr = ent[23:16]; e_data = ent[15:0];
            if (pend.size() == 0) m_after = 1;
         end
      end else if (m_after == 1) begin
         m_after = 2;
      end else begin
         m_after = 0;
         nb = 0;
      end
      m_busy = nb;
      e_busy = nb;
      e_done = (m_after == 2);
   endtask

   task automatic step();
      bit slot_now;
      slot_now = clk7_en & ~cck;
      @(posedge clk);
      model_edge(slot_now);
      #1;
      cyc++;
      chk("reg_wr", 32'(reg_wr), 32'(e_wr));
      chk("reg_address_out", 32'(reg_address_out), 32'(e_addr));
      chk("data_out", 32'(data_out), 32'(e_data));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      if (reg_wr === 1'b1) begin
         wr_count++;
         last_wr_cyc = cyc;
      end
      if (done === 1'b1) done_count++;
      phase = (phase + 1) % 8;
      clk7_en = (phase % 4) == 0;
      cck = (phase >= 4);
      start = 0;
      cpu_wr = 0;
      reset_n = 1;
   endtask

   task automatic wait_slot();
      int n = 0;
      while (phase != 0 && n < 16) begin step(); n++; end
   endtask

   task automatic run_to_idle(input string tag);
      int n = 0;
      do begin step(); n++; end while (m_busy && n < 300);
      chk({tag, "_idle_in_budget"}, 32'(busy), 32'd0);
   endtask

   task automatic clear_counts();
      wr_count = 0; done_count = 0; gap_bad = 0; last_wr_cyc = -1;
   endtask

   initial begin
      // reset
      reset_n = 0;
      step();
      chk("reset_reg_wr", 32'(reg_wr), 32'd0);
      chk("reset_addr", 32'(reg_address_out), 32'hFF);
      step();

      // mode 2, no CPU traffic, start issued on a slot cycle
      wait_slot();
      clear_counts();
      begin
         int prev = -1;
         int start_cyc;
         start = 1; mode_sel = 2'd2;
         start_cyc = cyc;
         for (int n = 0; n < 120 && m_busy | (n == 0); n++) begin
            step();
            if (reg_wr === 1'b1) begin
               if (prev >= 0 && cyc - prev != 8) gap_bad++;
               prev = cyc;
            end
         end
         chk("m2_write_count", 32'(wr_count), 32'd12);
         chk("m2_gap_8", 32'(gap_bad), 32'd0);
         chk("m2_done_count", 32'(done_count), 32'd1);
         chk("m2_last_latency_ok", 32'(last_wr_cyc - start_cyc <= 97), 32'd1);
      end
      repeat (3) step();

      // mode 0
      clear_counts();
      start = 1; mode_sel = 2'd0;
      run_to_idle("m0");
      chk("m0_write_count", 32'(wr_count), 32'd1);

      // mode 2 with CPU write on the third slot cycle of the run
      repeat (5) step();
      clear_counts();
      start = 1; mode_sel = 2'd2;
      step();
      for (int k = 0; k < 2; k++) begin wait_slot(); step(); end
      wait_slot();
      cpu_wr = 1; cpu_reg_address_in = 8'h48; cpu_data_in = 16'h1234;
      step();
      chk("cpu_addr", 32'(reg_address_out), 32'h48);
      chk("cpu_data", 32'(data_out), 32'h1234);
      run_to_idle("m2cpu");
      chk("m2cpu_total", 32'(wr_count), 32'd13);

      // mode 3 rejected
      repeat (2) step();
      clear_counts();
      start = 1; mode_sel = 2'd3;
      step();
      chk("m3_err", 32'(err), 32'd1);
      chk("m3_busy", 32'(busy), 32'd0);
      repeat (10) step();
      chk("m3_no_write", 32'(wr_count), 32'd0);

      // second start while busy is ignored
      clear_counts();
      start = 1; mode_sel = 2'd2;
      repeat (20) step();
      start = 1; mode_sel = 2'd1;
      run_to_idle("m2_ignore");
      chk("m2_ignore_count", 32'(wr_count), 32'd12);

      // reset after fifth write, then mode 0
      clear_counts();
      start = 1; mode_sel = 2'd2;
      for (int n = 0; n < 100 && wr_count < 5; n++) step();
      chk("m2_reached_5", 32'(wr_count), 32'd5);
      reset_n = 0;
      step();
      chk("rst_mid_busy", 32'(busy), 32'd0);
      clear_counts();
      repeat (120) step();
      chk("rst_mid_no_write", 32'(wr_count), 32'd0);
      chk("rst_mid_no_done", 32'(done_count), 32'd0);
      start = 1; mode_sel = 2'd0;
      run_to_idle("post_rst_m0");
      chk("post_rst_m0_count", 32'(wr_count), 32'd1);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 29) == 0) begin
            start = 1; mode_sel = 2'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 7) == 0) begin
            cpu_wr = 1;
            cpu_reg_address_in = 8'($urandom);
            cpu_data_in = 16'($urandom);
         end
         if ($urandom_range(0, 599) == 0) reset_n = 0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
